// File: rtl/uv_spi_engine_if.sv
// Queue-side handshake bundle for the SPI shift engine: TX dequeue and RX enqueue.
interface uv_spi_engine_if;
   logic        txq_empty;
   logic [31:0] txq_deq_dat;
   logic        txq_deq_vld;
   logic        rxq_full;
   logic        rx_enq_vld;
   logic [31:0] rx_enq_dat;

   modport master (
      input  txq_empty, txq_deq_dat, rxq_full,
      output txq_deq_vld, rx_enq_vld, rx_enq_dat
   );

   modport slave (
      output txq_empty, txq_deq_dat, rxq_full,
      input  txq_deq_vld, rx_enq_vld, rx_enq_dat
   );
endinterface

// File: rtl/uv_spi_engine.sv
// SPI master shift engine: pulls words from the TX queue, serialises them on
// SCK/MOSI/CS, samples MISO and optionally pushes the captured word to the RX queue.
//
// state | meaning
// IDLE  | CS at idle levels, SCK at cpol, waiting for a TX word and RX space
// LEAD  | CS asserted, SCK parked at cpol for sck_dly+1 cycles
// SHIFT | 2N SCK half-periods of clk_div+1 cycles each
// TRAIL | CS still asserted, SCK at cpol for sck_dly+1 cycles, then RX push
module uv_spi_engine #(
   parameter int CS_NUM = 4
) (
   input  logic              clk,
   input  logic              rst,
   uv_spi_engine_if.master   q_if,
   input  logic              spi_cpol,
   input  logic              spi_cpha,
   input  logic              spi_rxen,
   input  logic [4:0]        spi_unit,
   input  logic [7:0]        sck_dly,
   input  logic [15:0]       clk_div,
   input  logic              endian,
   input  logic [CS_NUM-1:0] def_idle,
   input  logic [CS_NUM-1:0] spi_mask,
   output logic              spi_sck,
   output logic [CS_NUM-1:0] spi_cs,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   state_t            state_q, state_d;
   logic [16:0]       cnt_q, cnt_d;
   logic [6:0]        tog_q, tog_d;
   logic [4:0]        tx_bit_q, tx_bit_d;
   logic [4:0]        rx_bit_q, rx_bit_d;
   logic [31:0]       tx_dat_q, tx_dat_d;
   logic [31:0]       rx_dat_q, rx_dat_d;

   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              rxen_q, rxen_d;
   logic [4:0]        unit_q, unit_d;
   logic [7:0]        dly_q, dly_d;
   logic [15:0]       div_q, div_d;
   logic              endian_q, endian_d;
   logic [CS_NUM-1:0] idle_q, idle_d;
   logic [CS_NUM-1:0] mask_q, mask_d;

   logic              sck_q, sck_d;
   logic [CS_NUM-1:0] cs_q, cs_d;
   logic              mosi_q, mosi_d;
   logic              busy_q, busy_d;
   logic              txq_deq_vld_q, txq_deq_vld_d;
   logic              rx_enq_vld_q, rx_enq_vld_d;
   logic [31:0]       rx_enq_dat_q, rx_enq_dat_d;

   logic              start;
   logic              lead_edge;
   logic              last_tog;
   logic              sample_now;
   logic              shift_now;

   // Position of the n-th transferred bit inside the frame.
   function automatic logic [4:0] bit_pos(input logic lsb_first, input logic [4:0] unit,
                                          input logic [4:0] n);
      return lsb_first ? n : unit - n;
   endfunction

   // A push still in flight this cycle is not yet reflected in rxq_full, so it
   // also holds off the next frame when receive is enabled.
   assign start = !q_if.txq_empty && !(spi_rxen && (q_if.rxq_full || rx_enq_vld_q));

   // Next-state and next-output computation for the whole engine.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tog_d         = tog_q;
      tx_bit_d      = tx_bit_q;
      rx_bit_d      = rx_bit_q;
      tx_dat_d      = tx_dat_q;
      rx_dat_d      = rx_dat_q;
      cpol_d        = cpol_q;
      cpha_d        = cpha_q;
      rxen_d        = rxen_q;
      unit_d        = unit_q;
      dly_d         = dly_q;
      div_d         = div_q;
      endian_d      = endian_q;
      idle_d        = idle_q;
      mask_d        = mask_q;
      sck_d         = sck_q;
      cs_d          = cs_q;
      mosi_d        = mosi_q;
      busy_d        = busy_q;
      txq_deq_vld_d = 1'b0;
      rx_enq_vld_d  = 1'b0;
      rx_enq_dat_d  = rx_enq_dat_q;
      lead_edge     = ~tog_q[0];
      last_tog      = (tog_q == {1'b0, unit_q, 1'b1});
      sample_now    = 1'b0;
      shift_now     = 1'b0;

      case (state_q)
         IDLE: begin
            sck_d  = spi_cpol;
            cs_d   = def_idle;
            mosi_d = 1'b0;
            busy_d = 1'b0;
            if (start) begin
               state_d       = LEAD;
               cnt_d         = {9'd0, sck_dly};
               tog_d         = '0;
               tx_bit_d      = '0;
               rx_bit_d      = '0;
               tx_dat_d      = q_if.txq_deq_dat;
               rx_dat_d      = '0;
               cpol_d        = spi_cpol;
               cpha_d        = spi_cpha;
               rxen_d        = spi_rxen;
               unit_d        = spi_unit;
               dly_d         = sck_dly;
               div_d         = clk_div;
               endian_d      = endian;
               idle_d        = def_idle;
               mask_d        = spi_mask;
               txq_deq_vld_d = 1'b1;
               busy_d        = 1'b1;
               cs_d          = def_idle ^ spi_mask;
               mosi_d        = q_if.txq_deq_dat[endian ? 5'd0 : spi_unit];
            end
         end

         LEAD: begin
            if (cnt_q == '0) begin
               state_d = SHIFT;
               cnt_d   = {1'b0, div_q};
            end else begin
               cnt_d = cnt_q - 17'd1;
            end
         end

         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 17'd1;
            end else begin
               cnt_d      = {1'b0, div_q};
               sck_d      = ~sck_q;
               tog_d      = tog_q + 7'd1;
               // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
               sample_now = lead_edge ^ cpha_q;
               // CPHA=1 keeps the LEAD-driven first bit through the first leading edge.
               shift_now  = cpha_q ? (lead_edge && (tog_q != '0)) : (!lead_edge && !last_tog);
               if (sample_now) begin
                  rx_dat_d[bit_pos(endian_q, unit_q, rx_bit_q)] = spi_miso;
                  rx_bit_d = rx_bit_q + 5'd1;
               end
               if (shift_now) begin
                  tx_bit_d = tx_bit_q + 5'd1;
                  mosi_d   = tx_dat_q[bit_pos(endian_q, unit_q, tx_bit_q + 5'd1)];
               end
               if (last_tog) begin
                  state_d = TRAIL;
                  cnt_d   = {9'd0, dly_q};
               end
            end
         end

         TRAIL: begin
            if (cnt_q == '0) begin
               state_d      = IDLE;
               busy_d       = 1'b0;
               cs_d         = def_idle;
               sck_d        = spi_cpol;
               mosi_d       = 1'b0;
               rx_enq_vld_d = rxen_q;
               if (rxen_q) begin
                  rx_enq_dat_d = rx_dat_q;
               end
            end else begin
               cnt_d = cnt_q - 17'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         tog_q         <= '0;
         tx_bit_q      <= '0;
         rx_bit_q      <= '0;
         tx_dat_q      <= '0;
         rx_dat_q      <= '0;
         cpol_q        <= 1'b0;
         cpha_q        <= 1'b0;
         rxen_q        <= 1'b0;
         unit_q        <= '0;
         dly_q         <= '0;
         div_q         <= '0;
         endian_q      <= 1'b0;
         idle_q        <= '1;
         mask_q        <= '0;
         sck_q         <= 1'b0;
         cs_q          <= '1;
         mosi_q        <= 1'b0;
         busy_q        <= 1'b0;
         txq_deq_vld_q <= 1'b0;
         rx_enq_vld_q  <= 1'b0;
         rx_enq_dat_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tog_q         <= tog_d;
         tx_bit_q      <= tx_bit_d;
         rx_bit_q      <= rx_bit_d;
         tx_dat_q      <= tx_dat_d;
         rx_dat_q      <= rx_dat_d;
         cpol_q        <= cpol_d;
         cpha_q        <= cpha_d;
         rxen_q        <= rxen_d;
         unit_q        <= unit_d;
         dly_q         <= dly_d;
         div_q         <= div_d;
         endian_q      <= endian_d;
         idle_q        <= idle_d;
         mask_q        <= mask_d;
         sck_q         <= sck_d;
         cs_q          <= cs_d;
         mosi_q        <= mosi_d;
         busy_q        <= busy_d;
         txq_deq_vld_q <= txq_deq_vld_d;
         rx_enq_vld_q  <= rx_enq_vld_d;
         rx_enq_dat_q  <= rx_enq_dat_d;
      end
   end

   assign spi_sck          = sck_q;
   assign spi_cs           = cs_q;
   assign spi_mosi         = mosi_q;
   assign busy             = busy_q;
   assign q_if.txq_deq_vld = txq_deq_vld_q;
   assign q_if.rx_enq_vld  = rx_enq_vld_q;
   assign q_if.rx_enq_dat  = rx_enq_dat_q;

endmodule

// File: tb/tb_uv_spi_engine.sv
// Directed bench for uv_spi_engine: queue model, MISO loopback/tie, edge monitor.
module tb_uv_spi_engine;
   localparam int CS_NUM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic              cpol = 1'b1, cpha = 1'b0, rxen = 1'b1, endian = 1'b0;
   logic [4:0]        unit = 5'd7;
   logic [7:0]        dly = 8'd0;
   logic [15:0]       div = 16'd1;
   logic [CS_NUM-1:0] def_idle = 4'hA, mask = 4'b0001;
   logic              rxq_full = 1'b0;
   logic              miso_loop = 1'b1, miso_val = 1'b0;
   logic              spi_sck, spi_mosi, spi_miso, busy;
   logic [CS_NUM-1:0] spi_cs;

   uv_spi_engine_if q_if();

   logic [31:0] tx_mem [0:15];
   int          tx_wr = 0, tx_rd = 0;
   assign q_if.txq_empty   = (tx_rd == tx_wr);
   assign q_if.txq_deq_dat = tx_mem[tx_rd[3:0]];
   assign q_if.rxq_full    = rxq_full;
   always @(posedge clk) if (q_if.txq_deq_vld) tx_rd <= tx_rd + 1;

   assign spi_miso = miso_loop ? spi_mosi : miso_val;

   uv_spi_engine #(.CS_NUM(CS_NUM)) dut (
      .clk(clk), .rst(rst), .q_if(q_if),
      .spi_cpol(cpol), .spi_cpha(cpha), .spi_rxen(rxen), .spi_unit(unit),
      .sck_dly(dly), .clk_div(div), .endian(endian), .def_idle(def_idle),
      .spi_mask(mask), .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .busy(busy)
   );

   int total = 0, bad = 0;
   int cyc = 0, deq_cyc = 0, cs_on_cyc = 0, cs_off_cyc = 0, last_tog_cyc = 0;
   int deq_cnt, enq_cnt, done_cnt, tog_cnt, lead_edges, cs_bad, frame_tog;
   int flen_min, flen_max, lead_min, lead_max, trail_min, trail_max;
   int gap_min, gap_max, cs_gap_min, cs_off_seen;
   logic [31:0] rx_last, rx_sum, mosi_seq;
   logic sck_prev = 1'b0, cs_act_prev = 1'b0, cs_act;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      deq_cnt = 0; enq_cnt = 0; done_cnt = 0; tog_cnt = 0; lead_edges = 0;
      cs_bad = 0; frame_tog = 0; cs_off_seen = 0;
      flen_min = 1000000; flen_max = 0; lead_min = 1000000; lead_max = 0;
      trail_min = 1000000; trail_max = 0; gap_min = 1000000; gap_max = 0;
      cs_gap_min = 1000000; rx_last = '0; rx_sum = '0; mosi_seq = '0;
   endtask

   // One clock: sample on the falling edge, update the monitor, drive after.
   task automatic tick();
      int d;
      @(negedge clk);
      cyc++;
      cs_act = (spi_cs != def_idle);
      if (!rst) begin
         if (q_if.txq_deq_vld) begin deq_cnt++; deq_cyc = cyc; end
         if (q_if.rx_enq_vld) begin
            enq_cnt++; rx_last = q_if.rx_enq_dat; rx_sum = rx_sum + q_if.rx_enq_dat;
            d = cyc - deq_cyc;
            if (d < flen_min) flen_min = d;
            if (d > flen_max) flen_max = d;
         end
         if (cs_act && !cs_act_prev) begin
            cs_on_cyc = cyc; frame_tog = 0;
            if (cs_off_seen != 0 && (cyc - cs_off_cyc) < cs_gap_min) cs_gap_min = cyc - cs_off_cyc;
         end
         if (spi_sck != sck_prev) begin
            tog_cnt++;
            if (frame_tog == 0) begin
               d = cyc - cs_on_cyc;
               if (d < lead_min) lead_min = d;
               if (d > lead_max) lead_max = d;
            end else begin
               d = cyc - last_tog_cyc;
               if (d < gap_min) gap_min = d;
               if (d > gap_max) gap_max = d;
            end
            frame_tog++;
            last_tog_cyc = cyc;
            if (spi_sck != cpol) lead_edges++;
            if ((spi_sck != cpol) != cpha) mosi_seq = {mosi_seq[30:0], spi_mosi};
         end
         if (!cs_act && cs_act_prev) begin
            d = cyc - last_tog_cyc;
            if (d < trail_min) trail_min = d;
            if (d > trail_max) trail_max = d;
            done_cnt++; cs_off_cyc = cyc; cs_off_seen = 1;
         end
         if (busy ? (spi_cs !== (def_idle ^ mask)) : (spi_cs !== def_idle)) cs_bad++;
      end
      sck_prev = spi_sck;
      cs_act_prev = cs_act;
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      tx_mem[tx_wr[3:0]] = w;
      tx_wr++;
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int k = 0; k < budget && done_cnt < n; k++) tick();
      chk("frame_timeout", done_cnt >= n, 1);
   endtask

   initial begin
      clr();
      // Reset values, with cpol=1 and def_idle=A to show reset overrides them.
      tick(); tick(); tick();
      chk("rst_sck", spi_sck, 0);
      chk("rst_cs", spi_cs, 4'hF);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_deq", q_if.txq_deq_vld, 0);
      chk("rst_enq", q_if.rx_enq_vld, 0);
      chk("rst_rxdat", q_if.rx_enq_dat, 0);
      rst = 1'b0;
      tick(); tick();
      chk("idle_sck_cpol", spi_sck, 1);
      chk("idle_cs_defidle", spi_cs, 4'hA);

      // Mode 0, MSB first, loopback of 0xA5.
      cpol = 1'b0; cpha = 1'b0; endian = 1'b0; unit = 5'd7; div = 16'd1; dly = 8'd0;
      mask = 4'b0001; def_idle = 4'hF; miso_loop = 1'b1;
      tick(); tick(); tick();
      clr();
      chk("t1_cs_idle", spi_cs, 4'hF);
      push(32'h0000_00A5);
      wait_done(1, 200);
      chk("t1_deq", deq_cnt, 1);
      chk("t1_enq", enq_cnt, 1);
      chk("t1_rx", rx_last, 32'h0000_00A5);
      chk("t1_mosi_seq", mosi_seq, 32'h0000_00A5);
      chk("t1_rise", lead_edges, 8);
      chk("t1_toggles", tog_cnt, 16);
      chk("t1_half_min", gap_min, 2);
      chk("t1_half_max", gap_max, 2);
      chk("t1_cs_bad", cs_bad, 0);
      chk("t1_flen", flen_max, 34);
      chk("t1_lead", lead_max, 3);
      chk("t1_trail", trail_max, 1);

      // Mode 3, LSB first, MISO tied high.
      cpol = 1'b1; cpha = 1'b1; endian = 1'b1; miso_loop = 1'b0; miso_val = 1'b1;
      tick(); tick(); tick();
      clr();
      chk("t2_sck_idle_hi", spi_sck, 1);
      push(32'h0000_003C);
      wait_done(1, 200);
      chk("t2_rx", rx_last, 32'h0000_00FF);
      chk("t2_mosi_seq", mosi_seq, 32'h0000_003C);
      chk("t2_lead_edges", lead_edges, 8);
      chk("t2_flen", flen_max, 34);
      tick();
      chk("t2_sck_after", spi_sck, 1);

      // Mode 1, LSB first, loopback; TX bits above unit are ignored.
      cpol = 1'b0; cpha = 1'b1; endian = 1'b1; miso_loop = 1'b1;
      tick(); tick(); tick();
      clr();
      push(32'hFFFF_FFC1);
      wait_done(1, 200);
      chk("t2b_rx", rx_last, 32'h0000_00C1);
      chk("t2b_mosi_seq", mosi_seq, 32'h0000_0083);

      // Full 32-bit frame at the fastest SCK.
      cpha = 1'b0; endian = 1'b0; unit = 5'd31; div = 16'd0;
      tick(); tick();
      clr();
      push(32'h1234_5678);
      wait_done(1, 300);
      chk("t3_toggles", tog_cnt, 64);
      chk("t3_half_max", gap_max, 1);
      chk("t3_rx", rx_last, 32'h1234_5678);
      chk("t3_mosi_seq", mosi_seq, 32'h1234_5678);
      chk("t3_flen", flen_max, 66);

      // RX full blocks the start only while receive is enabled.
      unit = 5'd7; div = 16'd1; rxen = 1'b1; rxq_full = 1'b1;
      tick(); tick();
      clr();
      push(32'h0000_005A);
      for (int k = 0; k < 10; k++) tick();
      chk("t4_no_deq", deq_cnt, 0);
      chk("t4_not_busy", busy, 0);
      rxq_full = 1'b0;
      wait_done(1, 200);
      chk("t4_rx", rx_last, 32'h0000_005A);
      clr();
      rxen = 1'b0; rxq_full = 1'b1;
      push(32'h0000_0066);
      wait_done(1, 200);
      tick(); tick();
      chk("t4_norx_deq", deq_cnt, 1);
      chk("t4_norx_enq", enq_cnt, 0);
      rxq_full = 1'b0; rxen = 1'b1;

      // Three back-to-back frames with a 4-cycle lead and trail.
      dly = 8'd3;
      tick(); tick();
      clr();
      push(32'h0000_0011); push(32'h0000_0022); push(32'h0000_0033);
      wait_done(3, 600);
      tick(); tick();
      chk("t5_enq", enq_cnt, 3);
      chk("t5_rx_last", rx_last, 32'h0000_0033);
      chk("t5_rx_sum", rx_sum, 32'h0000_0066);
      chk("t5_flen_min", flen_min, 40);
      chk("t5_flen_max", flen_max, 40);
      chk("t5_lead_min", lead_min, 6);
      chk("t5_lead_max", lead_max, 6);
      chk("t5_trail_min", trail_min, 4);
      chk("t5_trail_max", trail_max, 4);
      chk("t5_cs_gap", cs_gap_min >= 1, 1);
      chk("t5_cs_bad", cs_bad, 0);

      // Reset in the middle of the 5th bit aborts the frame.
      dly = 8'd0;
      tick(); tick();
      clr();
      push(32'h0000_00C3);
      for (int k = 0; k < 200 && lead_edges < 5; k++) tick();
      chk("t6_reach_bit5", lead_edges, 5);
      rst = 1'b1;
      tick();
      chk("t6_cs", spi_cs, 4'hF);
      chk("t6_sck", spi_sck, 0);
      chk("t6_busy", busy, 0);
      rst = 1'b0;
      for (int k = 0; k < 40; k++) tick();
      chk("t6_no_enq", enq_cnt, 0);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_cs", spi_cs, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
